seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the clock's six-digit, common-anode seven-segment display. It runs on the system clock, divides it down to a per-digit slot, and walks digit enables 0..5. It inserts a blanking gap at every digit change to suppress ghosting and can blink selected digits for time-setting mode. It sits between the BCD-to-segment decoders and the board pins, driving the same active-low `led`/`content` pin pair as the existing display path.

## Interface

Parameters:
- `SCAN_DIV`, 50000: clk cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all outputs dark; 0 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_FRAMES`, 64: full 6-digit frames per blink half-period; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: scanning on when high.
- `seg_bus` input 42: segment patterns, active-low; digit d is `seg_bus[7d+6:7d]`.
- `blink_mask` input 6: bit d=1 makes digit d blink.
- `led` output 8: digit enables, active-low; bits 7:6 are always 1.
- `content` output 7: segment drive, active-low.
- `digit_sel` output 3: index of the current slot, 0..5.
- `frame_done` output 1: one-cycle pulse at the end of the digit-5 slot.

## Operation

- States:
  - OFF: `led`=8'hFF, `content`=7'h7F.
  - BLANK: `led`=8'hFF, `content`=7'h7F.
  - SHOW: `led` bit `digit_sel` low, all others high; `content` = current digit slice.
- Slot counter `cnt` counts 0..SCAN_DIV-1 while enabled.
  - State is BLANK for cnt < BLANK_CYC and SHOW otherwise.
  - With BLANK_CYC=0, BLANK is never entered.
- At cnt = SCAN_DIV-1, `cnt` returns to 0 and `digit_sel` advances, wrapping 5→0.
  - On the 5→0 wrap, `frame_done` is high for that one cycle.
- `seg_bus` is sampled every cycle during SHOW. A pattern change takes effect on the next registered update; no latching per slot.
- Blink:
  - A frame counter counts `frame_done` pulses 0..BLINK_FRAMES-1 and toggles `blink_phase` on wrap.
  - When `blink_phase`=1 and `blink_mask[digit_sel]`=1, SHOW drives `content`=7'h7F while `led` is still asserted.
  - Blink timing continues while a digit is masked; clearing the mask restores the digit immediately.
- `enable` low:
  - Next clock: state OFF; `cnt`, `digit_sel`, frame counter and `blink_phase` cleared to 0.
  - `frame_done` stays 0.
- `enable` rising: the next cycle starts digit 0, cnt 0, in BLANK (or SHOW if BLANK_CYC=0).
- `rst` overrides `enable`. Reset values:
  - Outputs: `led`=8'hFF, `content`=7'h7F, `digit_sel`=0, `frame_done`=0.
  - Internal: state OFF, all counters 0, `blink_phase`=0.
- `rst` asserted mid-slot abandons the slot; no partial frame pulse.

## Timing

- All outputs are registered and follow the state/counter registers with one cycle latency.
- Slot length is exactly SCAN_DIV cycles; frame length is 6·SCAN_DIV cycles.
- Per slot, `led` is low for exactly SCAN_DIV−BLANK_CYC cycles.
- Blink period is 2·BLINK_FRAMES frames at 50% duty.
- The same-cycle slot wrap and frame wrap are handled in one cycle: `digit_sel`→0, `frame_done`=1 and the frame counter update together.
- Simultaneous `enable` fall and slot wrap: OFF wins; no `frame_done` is issued.

## Configuration

- Macro `SEG_SCAN_BLINK_EN`.
- Defined: blink logic (frame counter, `blink_phase`, mask gating) is compiled in as described above.
- Undefined:
  - Blink logic is removed and `blink_mask` is ignored.
  - SHOW always drives the `seg_bus` slice.
  - `frame_done` is still generated.

## Test plan

Bench parameters unless noted: SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset, then `enable`=1, `seg_bus`={6{7'h40}}:
  - Outputs dark for 2 cycles, then `led`=8'hFE and `content`=7'h40 for 6 cycles.
  - Then digit 1 sequence with `led`=8'hFD.
  - `frame_done` pulses once every 48 cycles.
- Distinct pattern per digit (d → 7'h10+d): each SHOW window shows the matching slice; `led` bits 7:6 never 0; `digit_sel` wraps 5→0.
- `blink_mask`=6'b000011, macro defined:
  - Frames 0–1 show all digits.
  - Frames 2–3 show `content`=7'h7F in slots 0–1 with `led` still low.
  - Digits 2–5 are unaffected.
- Same stimulus with macro undefined: digits 0–1 are never blanked in SHOW.
- Drop `enable` mid-slot of digit 3: outputs dark next cycle, `digit_sel`=0; re-enable restarts at digit 0, BLANK.
- Assert `rst` for 1 cycle with `enable` held high during digit 5 SHOW:
  - Outputs return to reset values; no `frame_done`.
  - Scanning resumes at digit 0 on the cycle after `rst` deasserts.
- BLANK_CYC=0: `led` is continuously active-low across slots and never reaches 8'hFF after the first enabled cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode scan controller: per-digit slots, blanking gap at each digit change, optional blink.
// Optional blink logic is compiled in when the macro SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [41:0] seg_bus,
  input  logic [5:0]  blink_mask,
  output logic [7:0]  led,
  output logic [6:0]  content,
  output logic [2:0]  digit_sel,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_LEN = (CNT_W + 1)'(BLANK_CYC);
  localparam logic [2:0]       DIG_LAST  = 3'd5;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       digit_r, digit_s;
  logic             frame_wrap_s;
  logic             running_s;
  logic             in_blank_s;
  logic             blank_digit_s;
  logic [6:0]       slice_s;
  logic [7:0]       led_r, led_s;
  logic [6:0]       content_r, content_s;
  logic             frame_done_r;

  assign running_s = (state_r == ST_BLANK) || (state_r == ST_SHOW);

  // Slot counter and digit walk; the first enabled cycle (or any illegal state) starts at digit 0, cnt 0.
  always_comb begin
    cnt_s        = cnt_r;
    digit_s      = digit_r;
    frame_wrap_s = 1'b0;
    if (!enable) begin
      cnt_s   = {CNT_W{1'b0}};
      digit_s = 3'd0;
    end else if (!running_s) begin
      cnt_s   = {CNT_W{1'b0}};
      digit_s = 3'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s = {CNT_W{1'b0}};
      if (digit_r == DIG_LAST) begin
        digit_s      = 3'd0;
        frame_wrap_s = 1'b1;
      end else begin
        digit_s = digit_r + 3'd1;
      end
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // cnt_s + 1 <= BLANK_CYC is cnt_s < BLANK_CYC without a constant-false compare when BLANK_CYC is 0.
  assign in_blank_s = ({1'b0, cnt_s} + (CNT_W + 1)'(1)) <= BLANK_LEN;

  // Next FSM state follows the slot position.
  always_comb begin
    state_s = ST_OFF;
    if (!enable) begin
      state_s = ST_OFF;
    end else if (in_blank_s) begin
      state_s = ST_BLANK;
    end else begin
      state_s = ST_SHOW;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FR_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt_r, frame_cnt_s;
  logic            blink_phase_r, blink_phase_s;
  logic            mask_bit_s;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames.
  always_comb begin
    frame_cnt_s   = frame_cnt_r;
    blink_phase_s = blink_phase_r;
    if (!enable) begin
      frame_cnt_s   = {FR_W{1'b0}};
      blink_phase_s = 1'b0;
    end else if (frame_wrap_s) begin
      if (frame_cnt_r == FR_LAST) begin
        frame_cnt_s   = {FR_W{1'b0}};
        blink_phase_s = ~blink_phase_r;
      end else begin
        frame_cnt_s = frame_cnt_r + FR_W'(1);
      end
    end else begin
      frame_cnt_s = frame_cnt_r;
    end
  end

  // Mask bit of the digit about to be shown.
  always_comb begin
    case (digit_s)
      3'd0:    mask_bit_s = blink_mask[0];
      3'd1:    mask_bit_s = blink_mask[1];
      3'd2:    mask_bit_s = blink_mask[2];
      3'd3:    mask_bit_s = blink_mask[3];
      3'd4:    mask_bit_s = blink_mask[4];
      3'd5:    mask_bit_s = blink_mask[5];
      default: mask_bit_s = 1'b1;
    endcase
  end

  assign blank_digit_s = blink_phase_s & mask_bit_s;

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r   <= {FR_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else begin
      frame_cnt_r   <= frame_cnt_s;
      blink_phase_r <= blink_phase_s;
    end
  end
`else
  logic mask_unused_s;
  assign mask_unused_s = ^blink_mask;
  assign blank_digit_s = 1'b0;
`endif

  // Digit enable and segment slice for the upcoming digit; out-of-range digits stay dark.
  always_comb begin
    led_s   = 8'hFF;
    slice_s = 7'h7F;
    case (digit_s)
      3'd0: begin led_s = 8'hFE; slice_s = seg_bus[6:0];   end
      3'd1: begin led_s = 8'hFD; slice_s = seg_bus[13:7];  end
      3'd2: begin led_s = 8'hFB; slice_s = seg_bus[20:14]; end
      3'd3: begin led_s = 8'hF7; slice_s = seg_bus[27:21]; end
      3'd4: begin led_s = 8'hEF; slice_s = seg_bus[34:28]; end
      3'd5: begin led_s = 8'hDF; slice_s = seg_bus[41:35]; end
      default: begin led_s = 8'hFF; slice_s = 7'h7F; end
    endcase
    if (state_s != ST_SHOW) begin
      led_s   = 8'hFF;
      content_s = 7'h7F;
    end else if (blank_digit_s) begin
      content_s = 7'h7F;
    end else begin
      content_s = slice_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_OFF;
      cnt_r        <= {CNT_W{1'b0}};
      digit_r      <= 3'd0;
      led_r        <= 8'hFF;
      content_r    <= 7'h7F;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      digit_r      <= digit_s;
      led_r        <= led_s;
      content_r    <= content_s;
      frame_done_r <= frame_wrap_s;
    end
  end

  assign led        = led_r;
  assign content    = content_r;
  assign digit_sel  = digit_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based display model predicts every cycle's outputs
// for two instances (BLANK_CYC=2 and BLANK_CYC=0) driven by the same directed and random stimulus.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 6 * SD;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [41:0] seg_bus = 42'd0;
  logic [5:0]  blink_mask = 6'd0;
  logic [7:0]  led0, led1;
  logic [6:0]  content0, content1;
  logic [2:0]  dsel0, dsel1;
  logic        fd0, fd1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .seg_bus(seg_bus), .blink_mask(blink_mask),
    .led(led0), .content(content0), .digit_sel(dsel0), .frame_done(fd0));

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_FRAMES(BF)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .seg_bus(seg_bus), .blink_mask(blink_mask),
    .led(led1), .content(content1), .digit_sel(dsel1), .frame_done(fd1));

  typedef struct {
    int         cyc;
    logic [7:0] led0;
    logic [6:0] con0;
    logic [7:0] led1;
    logic [6:0] con1;
    logic [2:0] dsel;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t = -1;  // cycles since scanning started, -1 when dark/off

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_led(int tt, int bc);
    logic [7:0] l;
    l = 8'hFF;
    if (tt >= 0 && (tt % SD) >= bc) l[(tt / SD) % 6] = 1'b0;
    return l;
  endfunction

  function automatic logic [6:0] exp_con(int tt, int bc, logic [41:0] s, logic [5:0] m);
    int d;
    if (tt < 0 || (tt % SD) < bc) return 7'h7F;
    d = (tt / SD) % 6;
    if (BLINK_ON && (((tt / FRAME) / BF) % 2 == 1) && m[d]) return 7'h7F;
    return s[7*d +: 7];
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, expv);
    end
  endtask

  // One input update; the expected outputs after the next clock edge go into the scoreboard.
  task automatic step(input logic r, input logic en, input logic [41:0] s, input logic [5:0] m);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; enable = en; seg_bus = s; blink_mask = m;
    if (r || !en) t = -1;
    else t = t + 1;
    e.cyc  = cyc + 1;
    e.led0 = exp_led(t, BC);
    e.con0 = exp_con(t, BC, s, m);
    e.led1 = exp_led(t, 0);
    e.con1 = exp_con(t, 0, s, m);
    e.dsel = (t < 0) ? 3'd0 : 3'((t / SD) % 6);
    e.fd   = (t > 0) && (t % FRAME == 0);
    q.push_back(e);
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      if (me.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL stale_entry cyc=%0d got=%0d exp=%0d", cyc, cyc, me.cyc);
      end else begin
        chk("led_b2",     led0,               me.led0);
        chk("content_b2", {1'b0, content0},   {1'b0, me.con0});
        chk("led_b0",     led1,               me.led1);
        chk("content_b0", {1'b0, content1},   {1'b0, me.con1});
        chk("digit_sel",  {5'd0, dsel0},      {5'd0, me.dsel});
        chk("digit_sel0", {5'd0, dsel1},      {5'd0, me.dsel});
        chk("frame_done", {7'd0, fd0},        {7'd0, me.fd});
        chk("frame_done0",{7'd0, fd1},        {7'd0, me.fd});
      end
    end
  end

  task automatic run_to(input int dig, input int off, input logic [41:0] s, input string nm);
    int i;
    i = 0;
    while (!(t >= 0 && (t / SD) % 6 == dig && t % SD == off) && i < 400) begin
      step(1'b0, 1'b1, s, 6'd0);
      i++;
    end
    checks++;
    if (i >= 400) begin
      failures++;
      $display("FAIL %s_timeout cyc=%0d got=%0d exp=%0d", nm, cyc, t, dig * SD + off);
    end
  endtask

  initial begin
    logic [41:0] seg40, segd, rseg;
    logic [5:0]  rmask;
    logic        ren;
    seg40 = {6{7'h40}};
    for (int d = 0; d < 6; d++) segd[7*d +: 7] = 7'(16 + d);

    repeat (3) step(1'b1, 1'b0, 42'd0, 6'd0);
    repeat (100) step(1'b0, 1'b1, seg40, 6'd0);

    // Restart so blink frames line up with the mask test.
    step(1'b0, 1'b0, segd, 6'b000011);
    repeat (4 * FRAME + 20) step(1'b0, 1'b1, segd, 6'b000011);

    // Drop enable in the middle of digit 3, then resume.
    run_to(3, 4, segd, "reach_digit3");
    repeat (3) step(1'b0, 1'b0, segd, 6'd0);
    repeat (30) step(1'b0, 1'b1, segd, 6'd0);

    // One-cycle reset during digit 5 SHOW with enable held high.
    run_to(5, 4, segd, "reach_digit5");
    step(1'b1, 1'b1, segd, 6'd0);
    repeat (60) step(1'b0, 1'b1, segd, 6'd0);

    // Random inputs: long enabled runs, occasional drops and resets, changing patterns and masks.
    ren = 1'b1; rseg = segd; rmask = 6'b010011;
    repeat (3000) begin
      if (ren && $urandom_range(0, 249) == 0) ren = 1'b0;
      else if (!ren && $urandom_range(0, 3) == 0) ren = 1'b1;
      if ($urandom_range(0, 7) == 0) rseg = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) rmask = 6'($urandom);
      step($urandom_range(0, 499) == 0, ren, rseg, rmask);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain cyc=%0d got=%0d exp=0", cyc, q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
